// File: rtl/mcalu.sv
// Multi-cycle accumulator ALU: single-cycle logic ops, iterative shift-add MUL and restoring DIV.
// Optional build macro MCALU_SAT_EN: saturating ADD/SUB that still load the accumulator.
module mcalu #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           opcode,
    input  logic                 src_acc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out,
    output logic                 err,
    output logic [WIDTH-1:0]     acc_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_CLR = 5'd0,  OP_NOT = 5'd1,  OP_SHR = 5'd2,  OP_SHL = 5'd3;
    localparam logic [4:0] OP_ADD = 5'd4,  OP_SUB = 5'd5,  OP_MUL = 5'd6,  OP_DIV = 5'd7;
    localparam logic [4:0] OP_AND = 5'd8,  OP_OR  = 5'd9,  OP_XOR = 5'd10, OP_NOP = 5'd11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    b_r;
    logic                is_div;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  work;

    logic [WIDTH-1:0]    x;
    logic [WIDTH:0]      add_s, sub_d;
    logic [2*WIDTH-1:0]  res;
    logic                rerr, acc_ld, multi;

    assign acc_out = acc;
    assign x       = src_acc ? acc : a;
    assign add_s   = {1'b0, x} + {1'b0, b};
    assign sub_d   = {1'b0, x} - {1'b0, b};
    assign multi   = (opcode == OP_MUL) || (opcode == OP_DIV && b != '0);

    // Single-cycle result path; MUL and DIV with b!=0 never take it.
    always_comb begin
        res  = '0;
        rerr = 1'b0;
        case (opcode)
            OP_CLR: res = '0;
            OP_NOT: res = {{WIDTH{1'b0}}, ~x};
            OP_SHR: res = {{WIDTH{1'b0}}, 1'b0, x[WIDTH-1:1]};
            OP_SHL: res = {{WIDTH{1'b0}}, x[WIDTH-2:0], 1'b0};
            OP_ADD: begin
                res  = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
                rerr = add_s[WIDTH];
`ifdef MCALU_SAT_EN
                if (add_s[WIDTH]) res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
`endif
            end
            OP_SUB: begin
                res  = {{WIDTH{1'b0}}, sub_d[WIDTH-1:0]};
                rerr = sub_d[WIDTH];
`ifdef MCALU_SAT_EN
                if (sub_d[WIDTH]) res = '0;
`endif
            end
            OP_DIV: rerr = 1'b1;
            OP_AND: res = {{WIDTH{1'b0}}, x & b};
            OP_OR:  res = {{WIDTH{1'b0}}, x | b};
            OP_XOR: res = {{WIDTH{1'b0}}, x ^ b};
            OP_NOP: res = {{WIDTH{1'b0}}, acc};
            default: rerr = 1'b1;
        endcase
`ifdef MCALU_SAT_EN
        acc_ld = !rerr || opcode == OP_ADD || opcode == OP_SUB;
`else
        acc_ld = !rerr;
`endif
    end

    // work holds {product-high, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [WIDTH:0]      mul_sum, top;
    logic [WIDTH-1:0]    diff;
    logic                ge;
    logic [2*WIDTH-1:0]  step;

    assign mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    assign top     = work[2*WIDTH-1:WIDTH-1];
    assign ge      = top >= {1'b0, b_r};
    assign diff    = top[WIDTH-1:0] - b_r;
    assign step    = is_div ? (ge ? {diff, work[WIDTH-2:0], 1'b1} : {work[2*WIDTH-2:0], 1'b0})
                            : {mul_sum, work[WIDTH-1:1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            err    <= 1'b0;
            acc    <= '0;
            b_r    <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
            work   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (multi) begin
                        b_r    <= b;
                        is_div <= (opcode == OP_DIV);
                        work   <= {{WIDTH{1'b0}}, x};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        out   <= res;
                        err   <= rerr;
                        if (acc_ld) acc <= res[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                RUN: begin
                    work <= step;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        out   <= step;
                        err   <= 1'b0;
                        acc   <= step[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcalu.sv
// Randomized bench for mcalu (WIDTH=16) against an arithmetic reference model, plus directed corner cases.
module tb_mcalu;

    localparam int     W = 16;
    localparam longint M = (64'd1 << W) - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [4:0]      opcode = '0;
    logic            src_acc = 1'b0;
    logic [W-1:0]    a = '0, b = '0;
    logic            busy, done, err;
    logic [2*W-1:0]  out;
    logic [W-1:0]    acc_out;

    int     errors = 0;
    int     checks = 0;
    longint macc   = 0;

    mcalu #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode), .src_acc(src_acc),
        .a(a), .b(b), .busy(busy), .done(done), .out(out), .err(err), .acc_out(acc_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, error and latency straight from the operation definitions.
    task automatic model(input int op, input longint x, input longint bv,
                         output longint o, output bit e, output int lat);
        bit sat = 0;
`ifdef MCALU_SAT_EN
        sat = 1;
`endif
        o = 0; e = 0; lat = 1;
        case (op)
            0:  o = 0;
            1:  o = ~x & M;
            2:  o = x >> 1;
            3:  o = (x << 1) & M;
            4:  begin e = (x + bv) > M; o = (x + bv) & M; if (e && sat) o = M; end
            5:  begin e = x < bv; o = (x - bv) & M; if (e && sat) o = 0; end
            6:  begin o = x * bv; lat = W + 1; end
            7:  if (bv == 0) e = 1; else begin o = ((x % bv) << W) | (x / bv); lat = W + 1; end
            8:  o = x & bv;
            9:  o = x | bv;
            10: o = x ^ bv;
            11: o = macc;
            default: e = 1;
        endcase
        if (!e || (sat && (op == 4 || op == 5))) macc = o & M;
    endtask

    task automatic do_op(input string tag, input int op, input bit sa,
                         input longint av, input longint bv, input bit inject = 0);
        longint eo; bit ee; int elat; int n; int nb;
        model(op, sa ? macc : av, bv, eo, ee, elat);
        @(negedge clock);
        start = 1; opcode = 5'(op); src_acc = sa; a = W'(av); b = W'(bv);
        @(posedge clock); #1;
        start = 0; opcode = 5'($urandom); a = W'($urandom); b = W'($urandom); src_acc = $urandom;
        n = 1; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (inject && n == 5) begin start = 1; opcode = 5'd4; end
            if (inject && n == 7) start = 0;
            @(posedge clock); #1;
            n++;
        end
        check({tag, "/lat"},  n, elat);
        check({tag, "/busyc"}, nb, elat - 1);
        check({tag, "/busy@done"}, busy, 0);
        check({tag, "/out"}, out, eo);
        check({tag, "/err"}, err, ee);
        check({tag, "/acc"}, acc_out, macc);
        @(posedge clock); #1;
        check({tag, "/pulse"}, done, 0);
    endtask

    initial begin
        #2;
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/out", out, 0);
        check("rst/err", err, 0);
        check("rst/acc", acc_out, 0);
        @(posedge clock); #1 reset = 0;

        do_op("add3+2", 4, 0, 3, 2);
        check("add3+2/lit", out, 32'h5);
        do_op("setacc", 4, 0, 16'h1234, 0);
        do_op("addovf", 4, 0, 16'hFFFF, 1);
        do_op("mulmax", 6, 0, 16'hFFFF, 16'hFFFF, 1);
        check("mulmax/lit", out, 32'hFFFE0001);
        do_op("div100/7", 7, 0, 100, 7);
        check("div/lit", out, 32'h0002000E);
        do_op("div0", 7, 0, 55, 0);
        do_op("acc5", 4, 0, 5, 0);
        do_op("shlacc", 3, 1, 0, 0);
        do_op("subacc", 5, 1, 0, 11);
        do_op("nop", 11, 0, 0, 0);
        do_op("ill", 20, 0, 1, 1);
        do_op("clr", 0, 0, 7, 7);

        // Abort a MUL in its eighth RUN cycle.
        @(negedge clock);
        start = 1; opcode = 5'd6; src_acc = 0; a = 16'h1234; b = 16'h5678;
        @(posedge clock); #1 start = 0;
        repeat (7) @(posedge clock);
        #2 reset = 1;
        #1;
        check("abort/busy", busy, 0);
        check("abort/done", done, 0);
        check("abort/out", out, 0);
        check("abort/err", err, 0);
        check("abort/acc", acc_out, 0);
        macc = 0;
        @(posedge clock); #1 reset = 0;
        do_op("post_rst", 4, 0, 1, 1);

        for (int i = 0; i < 200; i++) begin
            int op; longint av; longint bv;
            op = $urandom_range(0, 13);
            if (op > 11) op = $urandom_range(12, 31);
            av = $urandom & M;
            bv = $urandom & M;
            if ($urandom_range(0, 7) == 0) bv = 0;
            if ($urandom_range(0, 7) == 0) av = M;
            if (op == 6 && bv == 0) bv = 1;
            do_op($sformatf("rnd%0d_op%0d", i, op), op, $urandom_range(0, 1), av, bv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
